// File: rtl/reg_file_pkg.sv
// Shared types and defaults for the context-switching register file.
// Used by reg_file_ctx and reg_file_ctx_fsm.
package reg_file_pkg;

   localparam int unsigned DefDw = 8;
   localparam int unsigned DefAw = 4;

   typedef enum logic [1:0] {
      StIdle,
      StSave,
      StRestore
   } ctx_state_e;

endpackage

// File: rtl/reg_file_ctx_fsm.sv
// Context engine: sequences the register index for save/restore streams and
// issues the restore write strobe into the storage array.
module reg_file_ctx_fsm
   import reg_file_pkg::*;
#(
   parameter int unsigned AW = DefAw
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          ctx_save,
   input  logic          ctx_restore,
   input  logic          st_ready,
   input  logic          ld_valid,
   output logic          busy,
   output logic          st_valid,
   output logic          ld_ready,
   output logic [AW-1:0] idx,
   output logic          eng_we
);

   ctx_state_e    state_q;
   logic [AW-1:0] idx_q;
   logic          busy_q;
   logic          st_valid_q;
   logic          ld_ready_q;

   // idx wraps to zero by itself once the last register has been handshaken.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         idx_q      <= '0;
         busy_q     <= 1'b0;
         st_valid_q <= 1'b0;
         ld_ready_q <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (ctx_save) begin
                  state_q    <= StSave;
                  idx_q      <= '0;
                  busy_q     <= 1'b1;
                  st_valid_q <= 1'b1;
               end else if (ctx_restore) begin
                  state_q    <= StRestore;
                  idx_q      <= '0;
                  busy_q     <= 1'b1;
                  ld_ready_q <= 1'b1;
               end
            end
            StSave: begin
               if (st_ready) begin
                  idx_q <= idx_q + AW'(1);
                  if (idx_q == '1) begin
                     state_q    <= StIdle;
                     busy_q     <= 1'b0;
                     st_valid_q <= 1'b0;
                  end
               end
            end
            StRestore: begin
               if (ld_valid) begin
                  idx_q <= idx_q + AW'(1);
                  if (idx_q == '1) begin
                     state_q    <= StIdle;
                     busy_q     <= 1'b0;
                     ld_ready_q <= 1'b0;
                  end
               end
            end
            default: begin
               state_q    <= StIdle;
               idx_q      <= '0;
               busy_q     <= 1'b0;
               st_valid_q <= 1'b0;
               ld_ready_q <= 1'b0;
            end
         endcase
      end
   end

   assign busy     = busy_q;
   assign st_valid = st_valid_q;
   assign ld_ready = ld_ready_q;
   assign idx      = idx_q;
   assign eng_we   = (state_q == StRestore) && ld_valid;

endmodule

// File: rtl/reg_file_ctx.sv
// Register file with two operand ports, an accumulator port, optional write
// forwarding and a streaming save/restore context engine.
module reg_file_ctx
   import reg_file_pkg::*;
#(
   parameter int unsigned DW  = DefDw,
   parameter int unsigned AW  = DefAw,
   parameter bit          FWD = 1'b1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [DW-1:0] data_in,
   input  logic [AW-1:0] rd_addr_a,
   input  logic [AW-1:0] rd_addr_b,
   output logic [DW-1:0] opr_a_out,
   output logic [DW-1:0] opr_b_out,
   output logic [DW-1:0] acc_out,
   input  logic          ctx_save,
   input  logic          ctx_restore,
   output logic          busy,
   output logic          st_valid,
   input  logic          st_ready,
   output logic [DW-1:0] st_data,
   output logic [AW-1:0] st_idx,
   input  logic          ld_valid,
   output logic          ld_ready,
   input  logic [DW-1:0] ld_data
);

   localparam int unsigned Depth = 2 ** AW;

   logic [DW-1:0] core_q [Depth];
   logic [AW-1:0] eng_idx;
   logic          eng_we;
   logic          fwd_en;

   reg_file_ctx_fsm #(
      .AW (AW)
   ) u_fsm (
      .clk         (clk),
      .rst_n       (rst_n),
      .ctx_save    (ctx_save),
      .ctx_restore (ctx_restore),
      .st_ready    (st_ready),
      .ld_valid    (ld_valid),
      .busy        (busy),
      .st_valid    (st_valid),
      .ld_ready    (ld_ready),
      .idx         (eng_idx),
      .eng_we      (eng_we)
   );

   // Engine writes only happen while busy, so they never collide with port writes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < Depth; i++) begin
            core_q[i] <= '0;
         end
      end else if (eng_we) begin
         core_q[eng_idx] <= ld_data;
      end else if (wr_en && !busy) begin
         core_q[wr_addr] <= data_in;
      end
   end

   assign fwd_en = FWD && wr_en && !busy;

   always_comb begin
      opr_a_out = '0;
      if (rd_addr_a != '0) begin
         if (fwd_en && (wr_addr == rd_addr_a)) opr_a_out = data_in;
         else                                  opr_a_out = core_q[rd_addr_a];
      end
   end

   always_comb begin
      opr_b_out = '0;
      if (rd_addr_b != '0) begin
         if (fwd_en && (wr_addr == rd_addr_b)) opr_b_out = data_in;
         else                                  opr_b_out = core_q[rd_addr_b];
      end
   end

   always_comb begin
      acc_out = core_q[0];
      if (fwd_en && (wr_addr == '0)) acc_out = data_in;
   end

   assign st_data = core_q[eng_idx];
   assign st_idx  = eng_idx;

endmodule
